fp_adder_norm_round: RTL

//   Final stage of the FP adder: consumes the raw mantissa sum/difference from the mantissa-calculation stage.

---
 rtl/fp_adder_norm_round.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fp_adder_norm_round.sv
// Final FP adder stage: normalizes the raw mantissa one bit per cycle, rounds to nearest-even and packs the result.
// Latency 3 cycles accept-to-valid, plus one cycle per left shift; the result is held in DONE until out_ready.
module fp_adder_norm_round #(
  parameter int data_format = 0  // 0: FP32, 1: FP16, 2: FP64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [((data_format == 1) ? 10 : (data_format == 2) ? 52 : 23) + 4:0] in_mant,
  input  logic                  in_sign,
  input  logic [((data_format == 1) ? 5 : (data_format == 2) ? 11 : 8) - 1:0]    in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [((data_format == 1) ? 5 : (data_format == 2) ? 11 : 8) - 1:0]    out_exp,
  output logic [((data_format == 1) ? 10 : (data_format == 2) ? 52 : 23) - 1:0]  out_mant,
  output logic                  out_inexact,
  output logic                  out_overflow
);

  localparam int M = (data_format == 1) ? 10 : (data_format == 2) ? 52 : 23;
  localparam int P = 3;
  localparam int E = (data_format == 1) ? 5 : (data_format == 2) ? 11 : 8;
  localparam int W = M + P + 2;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t       state;
  logic [W-1:0] mant_q;
  logic [E:0]   exp_q;
  logic         sign_q;

  logic         rnd_lsb, rnd_g, rnd_rs, rnd_up;
  logic [M+1:0] rnd_sum;
  logic         rnd_carry, rnd_hidden, rnd_ovf;
  logic [E:0]   rnd_exp;

  // Rounding datapath; only consumed in ROUND, where the mantissa is already normalized.
  always_comb begin
    rnd_lsb    = mant_q[P];
    rnd_g      = mant_q[P-1];
    rnd_rs     = |mant_q[P-2:0];
    rnd_up     = rnd_g & (rnd_rs | rnd_lsb);
    rnd_sum    = mant_q[W-1:P] + {{(M+1){1'b0}}, rnd_up};
    rnd_carry  = rnd_sum[M+1];
    rnd_hidden = rnd_sum[M] | rnd_carry;
    rnd_exp    = exp_q + {{E{1'b0}}, rnd_carry};
    rnd_ovf    = rnd_exp >= (E+1)'((1 << E) - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_mant     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      mant_q       <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mant_q   <= in_mant;
            exp_q    <= {1'b0, in_exp};
            sign_q   <= in_sign;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            out_sign     <= sign_q;
            out_exp      <= '0;
            out_mant     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
            state        <= DONE;
          end else if (mant_q[W-1]) begin
            // Fold the shifted-out bit into sticky so rounding still sees it.
            mant_q <= {1'b0, mant_q[W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + (E+1)'(1);
            state  <= ROUND;
          end else if (mant_q[W-2] || exp_q <= (E+1)'(1)) begin
            state <= ROUND;
          end else begin
            mant_q <= {mant_q[W-2:0], 1'b0};
            exp_q  <= exp_q - (E+1)'(1);
          end
        end
        ROUND: begin
          out_sign    <= sign_q;
          out_inexact <= rnd_g | rnd_rs;
          if (rnd_ovf) begin
            out_exp      <= '1;
            out_mant     <= '0;
            out_overflow <= 1'b1;
          end else begin
            out_exp      <= rnd_hidden ? rnd_exp[E-1:0] : '0;
            out_mant     <= rnd_carry ? '0 : rnd_sum[M-1:0];
            out_overflow <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
